// File: rtl/wisc_pkg.sv
// Shared definitions for the forwarding/hazard controller: register-address
// width, operand-select encodings and the pipeline tag-slot record.
package wisc_pkg;

    localparam int REG_AW = 32'd4;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } tag_t;

    localparam tag_t TAG_NULL = '{
        valid:    1'b0,
        rd:       {REG_AW{1'b0}},
        regwrite: 1'b0,
        memread:  1'b0
    };

    // A slot forwards only when it really writes a non-zero register.
    function automatic logic fwd_hit(input tag_t t, input logic [REG_AW-1:0] addr);
        return t.valid & t.regwrite & (t.rd != {REG_AW{1'b0}}) & (t.rd == addr);
    endfunction

endpackage

// File: rtl/fwd_tag_slot.sv
// One pipeline tag register: asynchronously cleared, bubble beats load.
module fwd_tag_slot
    import wisc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    tag_t q_r;

    // Tag storage with bubble insertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= TAG_NULL;
        end else if (bubble) begin
            q_r <= TAG_NULL;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fwd_ctrl.sv
// EX-operand forwarding select generation and load-use stall detection for a
// five-stage pipeline, tracking destination tags in the EX, MEM and WB slots.
module fwd_ctrl #(
    parameter int REG_AW = wisc_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_imm_b,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic              ex_valid
);

    import wisc_pkg::*;

    tag_t       id_tag_s;
    tag_t       ex_tag_s;
    tag_t       mem_tag_s;
    tag_t       wb_tag_s;
    logic       load_hit_s;
    logic       stall_s;
    logic       ex_bubble_s;
    logic [1:0] sel_a_nx_s;
    logic [1:0] sel_b_nx_s;
    logic [1:0] sel_a_r;
    logic [1:0] sel_b_r;

    // Youngest producer wins; WB hits read the register file (write-before-read).
    function automatic logic [1:0] src_sel(
        input logic              used,
        input logic [REG_AW-1:0] addr,
        input tag_t              ex_t,
        input tag_t              mem_t,
        input tag_t              wb_t
    );
        if (!used) begin
            return SEL_RF;
        end else if (fwd_hit(ex_t, addr)) begin
            return SEL_EXMEM;
        end else if (fwd_hit(mem_t, addr)) begin
            return SEL_MEMWB;
        end else if (fwd_hit(wb_t, addr)) begin
            return SEL_RF;
        end else begin
            return SEL_RF;
        end
    endfunction

    // Pack the ID instruction into a tag for the EX slot.
    always_comb begin
        id_tag_s          = TAG_NULL;
        id_tag_s.valid    = id_valid;
        id_tag_s.rd       = id_rd;
        id_tag_s.regwrite = id_regwrite;
        id_tag_s.memread  = id_memread;
    end

    // Load-use detection against the instruction currently in EX; flush wins.
    always_comb begin
        load_hit_s = ex_tag_s.valid & ex_tag_s.memread
                   & (ex_tag_s.rd != {REG_AW{1'b0}})
                   & ((id_rs_used & (id_rs == ex_tag_s.rd))
                    | (id_rt_used & ~id_imm_b & (id_rt == ex_tag_s.rd)));
        if (flush) begin
            stall_s = 1'b0;
        end else if (id_valid) begin
            stall_s = load_hit_s;
        end else begin
            stall_s = 1'b0;
        end
        ex_bubble_s = flush | stall_s | ~id_valid;
    end

    // Next-cycle operand selects for the ID instruction.
    always_comb begin
        sel_a_nx_s = src_sel(id_rs_used, id_rs, ex_tag_s, mem_tag_s, wb_tag_s);
        if (id_imm_b) begin
            sel_b_nx_s = SEL_IMM;
        end else begin
            sel_b_nx_s = src_sel(id_rt_used, id_rt, ex_tag_s, mem_tag_s, wb_tag_s);
        end
    end

    // Registered selects; a bubble entering EX reads the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_r <= SEL_RF;
            sel_b_r <= SEL_RF;
        end else if (ex_bubble_s) begin
            sel_a_r <= SEL_RF;
            sel_b_r <= SEL_RF;
        end else begin
            sel_a_r <= sel_a_nx_s;
            sel_b_r <= sel_b_nx_s;
        end
    end

    fwd_tag_slot u_ex_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (ex_bubble_s),
        .d      (id_tag_s),
        .q      (ex_tag_s)
    );

    // MEM and WB advance every cycle, even while EX takes a bubble.
    fwd_tag_slot u_mem_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (ex_tag_s),
        .q      (mem_tag_s)
    );

    fwd_tag_slot u_wb_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (mem_tag_s),
        .q      (wb_tag_s)
    );

    assign stall    = stall_s;
    assign ex_sel_a = sel_a_r;
    assign ex_sel_b = sel_b_r;
    assign ex_valid = ex_tag_s.valid;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: instruction-history model plus directed
// hazard scenarios with literal expectations.
module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_rs = 4'd0;
    logic [3:0] id_rt = 4'd0;
    logic       id_rs_used = 1'b0;
    logic       id_rt_used = 1'b0;
    logic       id_imm_b = 1'b0;
    logic [3:0] id_rd = 4'd0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [1:0] ex_sel_a;
    logic [1:0] ex_sel_b;
    logic       ex_valid;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    fwd_ctrl #(.REG_AW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_imm_b    (id_imm_b),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .ex_sel_a    (ex_sel_a),
        .ex_sel_b    (ex_sel_b),
        .ex_valid    (ex_valid)
    );

    // Instructions that entered EX, youngest first: [0] now in EX, [1] in MEM, [2] in WB.
    typedef struct {
        bit       valid;
        bit [3:0] rd;
        bit       regwrite;
        bit       memread;
    } rec_t;

    rec_t     hist[3];
    bit [1:0] exp_a;
    bit [1:0] exp_b;
    bit       exp_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) hist[i] = '{default: 0};
        exp_a = 2'd0;
        exp_b = 2'd0;
        exp_v = 1'b0;
    endfunction

    function automatic bit model_stall();
        if (flush || !id_valid || !hist[0].valid || !hist[0].memread || hist[0].rd == 4'd0)
            return 1'b0;
        return (id_rs_used && id_rs == hist[0].rd) ||
               (id_rt_used && !id_imm_b && id_rt == hist[0].rd);
    endfunction

    function automatic bit [1:0] model_src(input bit used, input bit [3:0] a);
        if (!used) return 2'd0;
        for (int age = 0; age < 2; age++) begin
            if (hist[age].valid && hist[age].regwrite && hist[age].rd != 4'd0 && hist[age].rd == a)
                return (age == 0) ? 2'd1 : 2'd2;
        end
        return 2'd0;
    endfunction

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        rec_t e;
        if (rst_n) begin
            if (id_valid && !flush && !model_stall()) begin
                e.valid    = 1'b1;
                e.rd       = id_rd;
                e.regwrite = id_regwrite;
                e.memread  = id_memread;
                exp_v      = 1'b1;
                exp_a      = model_src(id_rs_used, id_rs);
                exp_b      = id_imm_b ? 2'd3 : model_src(id_rt_used, id_rt);
            end else begin
                e     = '{default: 0};
                exp_v = 1'b0;
                exp_a = 2'd0;
                exp_b = 2'd0;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_stall", {31'd0, stall}, {31'd0, model_stall()});
            chk("model_ex_valid", {31'd0, ex_valid}, {31'd0, exp_v});
            chk("model_ex_sel_a", {30'd0, ex_sel_a}, {30'd0, exp_a});
            chk("model_ex_sel_b", {30'd0, ex_sel_b}, {30'd0, exp_b});
        end
    end

    task automatic drive(input bit v, input bit [3:0] rs, input bit [3:0] rt,
                         input bit rsu, input bit rtu, input bit imm,
                         input bit [3:0] rd, input bit rw, input bit mr, input bit fl);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rs_used  = rsu;
        id_rt_used  = rtu;
        id_imm_b    = imm;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
    endtask

    task automatic nop();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        model_clear();
        #3;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("reset_sel_b", {30'd0, ex_sel_b}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check_en = 1'b1;

        // ADD R3 ; ADD R4,R3,R1 -> EX/MEM forward on A
        drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd3, 4'd1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        #1 chk("raw1_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("raw1_sel_a", {30'd0, ex_sel_a}, 32'd1);
        chk("raw1_sel_b", {30'd0, ex_sel_b}, 32'd0);
        chk("raw1_valid", {31'd0, ex_valid}, 32'd1);
        drain();

        // ADD R3 ; NOP ; SUB R5,R2,R3 -> MEM/WB forward on B
        drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        tick();
        chk("raw2_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("raw2_sel_b", {30'd0, ex_sel_b}, 32'd2);
        drain();

        // LW R6 ; ADD R7,R6,R6 -> one stall cycle then MEM/WB forward on both
        drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        #1 chk("lu_stall_on", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("lu_stall_off", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_sel_a", {30'd0, ex_sel_a}, 32'd2);
        chk("lu_sel_b", {30'd0, ex_sel_b}, 32'd2);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        drain();

        // ADD R0 ; ADD R1,R0,R0 -> no forwarding ; ADDI R2,R1,imm -> B=11
        drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("r0_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("r0_sel_b", {30'd0, ex_sel_b}, 32'd0);
        drive(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("imm_sel_a", {30'd0, ex_sel_a}, 32'd1);
        chk("imm_sel_b", {30'd0, ex_sel_b}, 32'd3);
        drain();

        // LW R6 ; consumer flushed -> no stall, bubble
        drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
        #1 chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        drain();

        // Reset pulse during a load-use stall
        drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        #1 chk("rst_pre_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_async_stall", {31'd0, stall}, 32'd0);
        chk("rst_async_sel_b", {30'd0, ex_sel_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_after_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("rst_after_sel_b", {30'd0, ex_sel_b}, 32'd0);
        chk("rst_after_valid", {31'd0, ex_valid}, 32'd1);
        drain();

        // Mixed traffic on a small register set, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            drive(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0));
            tick();
        end
        drain();

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
